// File: rtl/muldiv_sched.sv
// HI/LO multiply-divide sequencer: computes the result on accept, holds it for a
// fixed MULT/DIV latency, then commits it to HI/LO. Also serves MFHI/MFLO and stall.
module muldiv_sched #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        md_use,
  input  logic        rd_hi,
  input  logic        cancel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_ok;

  logic        is_start;
  logic        is_div;
  logic        div_zero;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_d;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_start = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign div_zero = (srcB == 32'd0);

  assign prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign prod_u = {32'd0, srcA} * {32'd0, srcB};

  // One unsigned divider serves both DIV and DIVU; signed division works on
  // magnitudes and fixes the signs afterwards (truncation toward zero).
  assign a_neg = (op == OP_DIV) && srcA[31];
  assign b_neg = (op == OP_DIV) && srcB[31];
  assign a_mag = a_neg ? (32'd0 - srcA) : srcA;
  assign b_mag = b_neg ? (32'd0 - srcB) : srcB;
  assign div_d = div_zero ? 32'd1 : b_mag;
  assign quo_u = a_mag / div_d;
  assign rem_u = a_mag % div_d;
  assign quo   = (a_neg ^ b_neg) ? (32'd0 - quo_u) : quo_u;
  assign rem   = a_neg ? (32'd0 - rem_u) : rem_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV,
      OP_DIVU: begin
        res_hi = rem;
        res_lo = quo;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_ok <= 1'b0;
    end else if (cancel) begin
      if (state == RUN) begin
        state   <= IDLE;
        cnt     <= 4'd0;
        pend_hi <= 32'd0;
        pend_lo <= 32'd0;
        pend_ok <= 1'b0;
      end
    end else if (state == IDLE) begin
      if (is_start) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_ok <= !(is_div && div_zero);
        cnt     <= is_div ? DIV_CNT : MUL_CNT;
        state   <= RUN;
      end else if (op == OP_MTHI) begin
        hi <= srcA;
      end else if (op == OP_MTLO) begin
        lo <= srcA;
      end
    end else begin
      // A divide by zero still spends its full latency but never commits.
      if (cnt == 4'd1) begin
        state <= IDLE;
        cnt   <= 4'd0;
        if (pend_ok) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign busy  = (state == RUN);
  assign stall = md_use && (busy || is_start);
  assign rdata = rd_hi ? hi : lo;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: a 64-bit arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO/busy/stall expectations.
module tb_muldiv_sched;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        md_use = 1'b0;
  logic        rd_hi = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  muldiv_sched #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .op(op), .srcA(srcA), .srcB(srcB),
    .md_use(md_use), .rd_hi(rd_hi), .cancel(cancel),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result as {hi, lo} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (o)
      3'd1: r = 64'(sa * sb);
      3'd2: r = ua * ub;
      3'd3: begin
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        uq = ua / ub;
        ur = ua % ub;
        r  = {ur[31:0], uq[31:0]};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Behavioural model: remaining busy cycles plus a held result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_pvalid = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left   = 0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;
      m_pvalid = 1'b0;
    end else if (m_left > 0) begin
      if (cancel) begin
        m_left = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0 && m_pvalid) {m_hi, m_lo} = m_pend;
      end
    end else if (!cancel) begin
      if (op >= 3'd1 && op <= 3'd4) begin
        m_left   = (op <= 3'd2) ? MUL_N : DIV_N;
        m_pvalid = !(op >= 3'd3 && srcB == 32'd0);
        if (m_pvalid) m_pend = ref_result(op, srcA, srcB);
      end else if (op == 3'd5) begin
        m_hi = srcA;
      end else if (op == 3'd6) begin
        m_lo = srcA;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("model_stall", {31'd0, stall},
            {31'd0, md_use && ((m_left > 0) || (op >= 3'd1 && op <= 3'd4))});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
      check("model_rdata", rdata, rd_hi ? m_hi : m_lo);
    end
  end

  task automatic step(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic md, input logic rh, input logic c);
    @(posedge clk);
    #1;
    op = o; srcA = a; srcB = b; md_use = md; rd_hi = rh; cancel = c;
    $display("txn op=%0d srcA=%h srcB=%h md_use=%0b rd_hi=%0b cancel=%0b",
             o, a, b, md, rh, c);
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (o <= 3'd2) ? MUL_N : DIV_N;
    step(o, a, b, 1'b1, 1'b0, 1'b0);
    mid();
    check("issue_start_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < n; i++) begin
      idle();
      mid();
      check("issue_run_busy", {31'd0, busy}, 32'd1);
    end
    idle();
    mid();
    check("issue_done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    mid();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Asynchronous reset in the middle of a MULT
    step(3'd5, 32'hAAAA5555, 32'd0, 1'b1, 1'b1, 1'b0);
    step(3'd6, 32'h00001234, 32'd0, 1'b1, 1'b0, 1'b0);
    step(3'd1, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    #2 reset = 1'b0;
    mid();
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    idle();
    reset = 1'b1;
    step(3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    mid();
    check("mfhi_after_rst", rdata, 32'd0);

    // MULT with MFLO waiting behind it; MTLO during busy must be ignored
    step(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0);
    mid();
    check("mult_t_stall", {31'd0, stall}, 32'd1);
    for (int i = 1; i <= MUL_N; i++) begin
      step((i == 3) ? 3'd6 : 3'd0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
      mid();
      check("mult_run_stall", {31'd0, stall}, 32'd1);
      check("mult_run_busy", {31'd0, busy}, 32'd1);
    end
    step(3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    mid();
    check("mult_done_stall", {31'd0, stall}, 32'd0);
    check("mult_rdata", rdata, 32'hFFFFFFFA);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    check("div_neg_lo", lo, 32'hFFFFFFFD);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_hi", hi, 32'h00000000);
    check("div_ovf_lo", lo, 32'h80000000);

    // DIVU by zero keeps preloaded HI/LO
    step(3'd5, 32'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    step(3'd6, 32'h22, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(3'd4, 32'd5, 32'd0);
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    // Cancel on the third busy cycle of a DIV
    step(3'd3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
    idle();
    idle();
    step(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    mid();
    check("cancel_run_busy", {31'd0, busy}, 32'd1);
    idle();
    mid();
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);
    repeat (DIV_N) idle();
    mid();
    check("cancel_late_hi", hi, 32'h11);
    check("cancel_late_lo", lo, 32'h22);

    // Cancel in IDLE suppresses MTHI
    step(3'd5, 32'h9, 32'd0, 1'b1, 1'b1, 1'b1);
    idle();
    mid();
    check("cancel_mthi_hi", hi, 32'h11);

    repeat (2) idle();
    mid();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencing controller for the pipeline's multiply/divide resource, which feeds muldivRes into the E/M pipeline register.
- Accepts one HI/LO operation per request from the E stage and models multi-cycle MULT/DIV latency with a counter FSM.
- Owns the architectural HI/LO registers, serves MFHI/MFLO reads, and raises a stall request so hazard logic freezes F/D while an md-class instruction in E must wait.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; low clears all state
- op  input  3  E-stage request: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
- srcA  input  32  forwarded rs value (F_regA1Data_E)
- srcB  input  32  forwarded rt value (F_regA2Data_E)
- md_use  input  1  E-stage instruction is md-class (any op or MFHI/MFLO)
- rd_hi  input  1  read select: 1 HI, 0 LO
- cancel  input  1  abort in-flight MULT/DIV (exception flush)
- busy  output  1  multi-cycle operation in progress
- stall  output  1  stall request to hazard unit
- hi  output  32  HI register
- lo  output  32  LO register
- rdata  output  32  rd_hi ? hi : lo, combinational (muldivRes_E source)

Behaviour:
- Reset (reset low, asynchronous): state IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0. Recovery is synchronous to the next clk edge.
- FSM states: IDLE, RUN.
- IDLE, op in 1..4: on the edge, compute the result into pend_hi/pend_lo, load cnt=MUL_CYCLES or DIV_CYCLES, and go to RUN.
- IDLE, op 5/6: on the edge, write srcA to hi/lo respectively; stay IDLE.
- RUN: cnt decrements each edge. The edge where cnt==1 commits pend_hi/pend_lo to hi/lo and returns to IDLE.
- busy = (state==RUN). The accept cycle is t; busy is high for cycles t+1..t+N; new hi/lo are visible from cycle t+N+1.
- stall = md_use & (busy | (op in 1..4)). The start cycle itself stalls so that a following MFHI/MFLO cannot advance early. The issuing instruction still advances to M: hazard logic must not freeze E when op started this cycle.
- Any op presented while busy is ignored. No FSM, hi/lo or cnt change. stall holds it upstream.
- cancel has priority over everything except reset:
  - In RUN: go to IDLE, cnt=0, hi/lo unchanged, pending result discarded.
  - In IDLE: suppresses that cycle's op, including MTHI/MTLO.
- Arithmetic, with the 64-bit product split {hi,lo}:
  - MULT: signed 32x32 product.
  - MULTU: unsigned 32x32 product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV/DIVU, srcB=0): FSM still runs DIV_CYCLES, but the commit leaves hi/lo unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are sampled only on the accept edge; later srcA/srcB changes during RUN have no effect.
- rdata is purely combinational on current hi/lo. It does not bypass pending results.

Test Plan:
- Reset low mid-RUN (after 2 of 5 MULT cycles) → busy=0, hi=lo=0 immediately. After release, MFHI reads 0.
- MULT srcA=0xFFFFFFFE, srcB=3 → busy for cycles t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy 10 cycles; hi/lo remain 0x11/0x22.
- MULT at t, then md_use=1 with MFLO held t+1..t+5 → stall=1 for cycles t..t+5, 0 at t+6; rdata=new lo at t+6. An MTLO 0x5 presented during busy is ignored.
- DIV started, cancel at 3rd busy cycle → next cycle busy=0, hi/lo unchanged. Same-cycle cancel with MTHI 0x9 in IDLE → hi unchanged.
